// File: rtl/exe_mdu_pkg.sv
// exe_mdu_pkg: shared widths, funct3 encodings and FSM state type for the
// RV32M multiply/divide unit. Define MDU_DIV_EN to build the divider path.
package exe_mdu_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int MDU_CNT_WIDTH  = 6;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } type_mdu_funct3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } type_mdu_state;

endpackage

// File: rtl/exe_mdu_if.sv
// exe_mdu_if: ID/EX-side request fields and MDU status/result bundle.
// master = pipeline side driving the op, slave = the MDU.
interface exe_mdu_if import exe_mdu_pkg::*; ();
  logic                      start;
  logic [2:0]                funct3;
  logic [DATA_WIDTH-1:0]     rs1_val;
  logic [DATA_WIDTH-1:0]     rs2_val;
  logic [REG_ADDR_WIDTH-1:0] rd_in;
  logic                      flush;
  logic                      stall_req;
  logic                      busy;
  logic                      done;
  logic [DATA_WIDTH-1:0]     result;
  logic [REG_ADDR_WIDTH-1:0] rd_out;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in, flush,
    input  stall_req, busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in, flush,
    output stall_req, busy, done, result, rd_out
  );
endinterface

// File: rtl/exe_mdu_div_core.sv
// mdu_div_core: unsigned restoring divider, one quotient bit per i_step.
// Operands are magnitudes; sign fix-up is done by the caller.
module mdu_div_core import exe_mdu_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic [DATA_WIDTH-1:0] o_quotient,
  output logic [DATA_WIDTH-1:0] o_remainder
);
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [DATA_WIDTH-1:0] r_div;
  logic [DATA_WIDTH:0]   w_shift;
  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_rem_next;

  // Trial subtract: the true difference always fits in DATA_WIDTH bits when
  // w_ge holds, so modular low-half subtraction is exact.
  always_comb begin
    w_shift    = {r_rem, r_quo[DATA_WIDTH-1]};
    w_ge       = (w_shift >= {1'b0, r_div});
    w_rem_next = w_ge ? (w_shift[DATA_WIDTH-1:0] - r_div) : w_shift[DATA_WIDTH-1:0];
  end

  // Load operands on accept, then shift one dividend bit in per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_div <= i_divisor;
    end else if (i_step) begin
      r_rem <= w_rem_next;
      r_quo <= {r_quo[DATA_WIDTH-2:0], w_ge};
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;
endmodule

// File: rtl/exe_mdu.sv
// exe_mdu: iterative RV32M multiply/divide unit for the EXE stage.
// Build option: MDU_DIV_EN enables the divider; without it funct3 1xx
// completes in one cycle with result 0.
module exe_mdu import exe_mdu_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  exe_mdu_if.slave    io_mdu
);
  type_mdu_state             r_state, w_state_next;
  logic [2:0]                r_funct3;
  logic [REG_ADDR_WIDTH-1:0] r_rd, r_rd_out;
  logic [DATA_WIDTH-1:0]     r_result, r_mcand;
  logic [MDU_CNT_WIDTH-1:0]  r_cnt;
  logic [2*DATA_WIDTH-1:0]   r_acc;
  logic                      r_neg_prod;
  logic                      w_accept, w_s1_neg, w_s2_neg, w_special;
  logic [DATA_WIDTH-1:0]     w_mag1, w_mag2, w_special_val, w_fix_val;
  logic [DATA_WIDTH:0]       w_sum;
  logic [2*DATA_WIDTH-1:0]   w_acc_step, w_prod;

  assign w_accept = (r_state == IDLE) && io_mdu.start && !io_mdu.flush;

  // Operand sign flags and magnitudes for the incoming op.
  always_comb begin
    w_s1_neg = io_mdu.rs1_val[DATA_WIDTH-1] && (io_mdu.funct3 != MDU_MULHU) &&
               (io_mdu.funct3 != MDU_DIVU) && (io_mdu.funct3 != MDU_REMU);
    w_s2_neg = io_mdu.rs2_val[DATA_WIDTH-1] &&
               ((io_mdu.funct3 == MDU_MUL) || (io_mdu.funct3 == MDU_MULH) ||
                (io_mdu.funct3 == MDU_DIV) || (io_mdu.funct3 == MDU_REM));
    w_mag1 = w_s1_neg ? -io_mdu.rs1_val : io_mdu.rs1_val;
    w_mag2 = w_s2_neg ? -io_mdu.rs2_val : io_mdu.rs2_val;
  end

`ifdef MDU_DIV_EN
  logic                  r_neg_rem;
  logic [DATA_WIDTH-1:0] w_quo, w_rem;
  logic                  w_div0, w_ovf;

  mdu_div_core u_div (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept && io_mdu.funct3[2]),
    .i_step      ((r_state == CALC) && r_funct3[2]),
    .i_dividend  (w_mag1),
    .i_divisor   (w_mag2),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  always_comb begin
    w_div0    = (io_mdu.rs2_val == '0);
    w_ovf     = ((io_mdu.funct3 == MDU_DIV) || (io_mdu.funct3 == MDU_REM)) &&
                (io_mdu.rs1_val == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (&io_mdu.rs2_val);
    w_special = io_mdu.funct3[2] && (w_div0 || w_ovf);
    if (w_div0)
      w_special_val = io_mdu.funct3[1] ? io_mdu.rs1_val : '1;
    else
      w_special_val = io_mdu.funct3[1] ? '0 : {1'b1, {(DATA_WIDTH-1){1'b0}}};
  end
`else
  // Divide ops are not supported in this build: finish at once with zero.
  always_comb begin
    w_special     = io_mdu.funct3[2];
    w_special_val = '0;
  end
`endif

  // One shift-add multiply step: conditionally add multiplicand to high half.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_acc_step = {w_sum, r_acc[DATA_WIDTH-1:1]};
    w_prod     = r_neg_prod ? -r_acc : r_acc;
  end

  // Sign correction and half/quotient/remainder selection for FIX.
  always_comb begin
    w_fix_val = '0;
    case (r_funct3)
      MDU_MUL:                         w_fix_val = w_prod[DATA_WIDTH-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_val = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef MDU_DIV_EN
      MDU_DIV, MDU_DIVU:               w_fix_val = r_neg_prod ? -w_quo : w_quo;
      MDU_REM, MDU_REMU:               w_fix_val = r_neg_rem ? -w_rem : w_rem;
`endif
      default:                         w_fix_val = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    w_state_next = r_state;
    if (io_mdu.flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (io_mdu.start) w_state_next = w_special ? DONE : CALC;
        CALC:    if (r_cnt == MDU_CNT_WIDTH'(1)) w_state_next = FIX;
        FIX:     w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    io_mdu.stall_req = w_accept || (r_state == CALC) || (r_state == FIX);
    io_mdu.busy      = (r_state == CALC) || (r_state == FIX);
    io_mdu.done      = (r_state == DONE) && !io_mdu.flush;
    io_mdu.result    = r_result;
    io_mdu.rd_out    = r_rd_out;
  end

  // Datapath: capture on accept, iterate in CALC, publish in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct3   <= '0;
      r_rd       <= '0;
      r_rd_out   <= '0;
      r_result   <= '0;
      r_mcand    <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_neg_prod <= 1'b0;
`ifdef MDU_DIV_EN
      r_neg_rem  <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_funct3   <= io_mdu.funct3;
        r_rd       <= io_mdu.rd_in;
        r_mcand    <= w_mag1;
        r_acc      <= {{DATA_WIDTH{1'b0}}, w_mag2};
        r_cnt      <= MDU_CNT_WIDTH'(DATA_WIDTH);
        r_neg_prod <= w_s1_neg ^ w_s2_neg;
`ifdef MDU_DIV_EN
        r_neg_rem  <= w_s1_neg;
`endif
        if (w_special) begin
          r_result <= w_special_val;
          r_rd_out <= io_mdu.rd_in;
        end
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt - MDU_CNT_WIDTH'(1);
        r_acc <= w_acc_step;
      end else if ((r_state == FIX) && !io_mdu.flush) begin
        r_result <= w_fix_val;
        r_rd_out <= r_rd;
      end
    end
  end
endmodule

// File: tb/tb_exe_mdu.sv
// tb_exe_mdu: directed + scoreboard bench for exe_mdu (default and MDU_DIV_EN builds).
module tb_exe_mdu;
  import exe_mdu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } sb_entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;
  sb_entry_t sb_q[$];

  exe_mdu_if mif ();
  exe_mdu dut (.clk(clk), .rst(rst), .io_mdu(mif));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference for multiplies using 64-bit modular arithmetic.
  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f3 == 3'b011) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = (f3 == 3'b010 || f3 == 3'b011) ? {32'b0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    return (f3 == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int        lat;
    bit        stall_bad;
    sb_entry_t e;
    sb_q.push_back('{name: name, res: exp_res, rd: rd, lat: exp_lat});
    @(posedge clk); #1;
    mif.start = 1'b1; mif.funct3 = f3; mif.rs1_val = a; mif.rs2_val = b; mif.rd_in = rd;
    #1;
    check({name, ".idle_done"}, 64'(mif.done), 64'(0));
    check({name, ".stall_at_T"}, 64'(mif.stall_req), 64'(1));
    @(posedge clk); #1;
    mif.start = 1'b0;
    lat = 1;
    stall_bad = 1'b0;
    while (mif.done !== 1'b1 && lat < 60) begin
      if (mif.stall_req !== 1'b1 || mif.busy !== 1'b1) stall_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    check({e.name, ".done"}, 64'(mif.done), 64'(1));
    check({e.name, ".latency"}, 64'(lat), 64'(e.lat));
    check({e.name, ".result"}, 64'(mif.result), 64'(e.res));
    check({e.name, ".rd_out"}, 64'(mif.rd_out), 64'(e.rd));
    check({e.name, ".stall_in_done"}, 64'(mif.stall_req), 64'(0));
    check({e.name, ".stall_while_busy"}, 64'(stall_bad), 64'(0));
    $display("txn %s f3=%0d rs1=%h rs2=%h result=%h rd=%0d lat=%0d",
             e.name, f3, a, b, mif.result, mif.rd_out, lat);
  endtask

  initial begin
    logic [31:0] ra, rb, held;
    logic [2:0]  rf;
    bit          saw_done;
    mif.start = 1'b0; mif.funct3 = '0; mif.rs1_val = '0; mif.rs2_val = '0;
    mif.rd_in = '0;   mif.flush = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 64'(mif.busy), 64'(0));
    check("rst.done", 64'(mif.done), 64'(0));
    check("rst.stall", 64'(mif.stall_req), 64'(0));
    check("rst.result", 64'(mif.result), 64'(0));
    check("rst.rd_out", 64'(mif.rd_out), 64'(0));
    rst = 1'b0;

    // Multiplies from the plan
    run_op("MUL_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 34);
    run_op("MULHU_m1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 34);
    run_op("MULH_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000, 34);
    run_op("MULHSU_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, 34);

    // Random multiplies against the reference model
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rf = 3'($urandom_range(0, 3));
      run_op($sformatf("MULrand%0d", i), rf, ra, rb, 5'(10 + i), ref_mul(rf, ra, rb), 34);
    end

`ifdef MDU_DIV_EN
    run_op("DIV_-7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 34);
    run_op("REM_-7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 34);
    run_op("DIVU_100/7", 3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 34);
    run_op("REMU_100/7", 3'b111, 32'd100, 32'd7, 5'd9, 32'd2, 34);
    run_op("DIV_5/0", 3'b100, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
    run_op("REM_5/0", 3'b110, 32'd5, 32'd0, 5'd12, 32'd5, 1);
    run_op("DIV_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
    run_op("REM_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 1);
`else
    run_op("DIVU_nodiv", 3'b101, 32'd100, 32'd7, 5'd9, 32'd0, 1);
    run_op("REM_nodiv", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'd0, 1);
`endif
    run_op("MUL_after_div", 3'b000, 32'd12345, 32'd678, 5'd15, 32'd8369910, 34);

    // Flush at T+10 of a MUL: back to IDLE at T+11, no done, restart at T+12
    held = mif.result;
    @(posedge clk); #1;
    mif.start = 1'b1; mif.funct3 = 3'b000; mif.rs1_val = 32'd3; mif.rs2_val = 32'd3; mif.rd_in = 5'd20;
    @(posedge clk); #1;
    mif.start = 1'b0;
    saw_done = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      @(posedge clk); #1;
      if (mif.done === 1'b1) saw_done = 1'b1;
    end
    mif.flush = 1'b1;
    #1;
    check("flush.done_T10", 64'(mif.done | saw_done), 64'(0));
    @(posedge clk); #1;
    mif.flush = 1'b0;
    #1;
    check("flush.busy_T11", 64'(mif.busy), 64'(0));
    check("flush.stall_T11", 64'(mif.stall_req), 64'(0));
    check("flush.done_T11", 64'(mif.done), 64'(0));
    check("flush.result_held", 64'(mif.result), 64'(held));
    run_op("MUL_after_flush", 3'b000, 32'd9, 32'd11, 5'd21, 32'd99, 34);

    // Flush arriving in DONE suppresses the done pulse
    @(posedge clk); #1;
    mif.start = 1'b1; mif.funct3 = 3'b100; mif.rs1_val = 32'd5; mif.rs2_val = 32'd0; mif.rd_in = 5'd22;
    @(posedge clk); #1;
    mif.start = 1'b0; mif.flush = 1'b1;
    #1;
    check("flush_done.done", 64'(mif.done), 64'(0));
    @(posedge clk); #1;
    mif.flush = 1'b0;
    #1;
    check("flush_done.next", 64'(mif.done), 64'(0));

    // Reset at T+5 of a MUL
    @(posedge clk); #1;
    mif.start = 1'b1; mif.funct3 = 3'b000; mif.rs1_val = 32'd6; mif.rs2_val = 32'd7; mif.rd_in = 5'd23;
    @(posedge clk); #1;
    mif.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstmid.busy_before", 64'(mif.busy), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid.busy", 64'(mif.busy), 64'(0));
    check("rstmid.done", 64'(mif.done), 64'(0));
    check("rstmid.stall", 64'(mif.stall_req), 64'(0));
    check("rstmid.result", 64'(mif.result), 64'(0));
    check("rstmid.rd_out", 64'(mif.rd_out), 64'(0));
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (mif.done === 1'b1) saw_done = 1'b1;
    end
    check("rstmid.no_done", 64'(saw_done), 64'(0));
    check("scoreboard.empty", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
